// File: rtl/pwm_timebase_if.sv
// -----------------------------------------------------------------------------
// pwm_timebase_if
// Purpose : groups the control, configuration and status signals of the PWM
//           timebase controller into one bundle.
//
// Handshake semantics: there is no valid/ready backpressure on this bundle.
// cfg_wr, start and stop are single-cycle request strobes that are always
// accepted on the rising clock edge where they are high. period_end and
// cfg_err are single-cycle registered event pulses, and the consumer must take
// them in that cycle. oneshot is a level input. tick is a one-cycle pulse from
// the prescaler.
//
// Signals (from the controller's point of view):
//   cfg_wr      in   config write strobe (captures cfg_div / cfg_period)
//   cfg_div     in   prescaler divide value (tick every cfg_div+1 cycles)
//   cfg_period  in   period length minus one, in ticks
//   start       in   start request strobe
//   stop        in   graceful stop request strobe
//   oneshot     in   level, end RUN after one period (optional feature)
//   tick        in   prescaler tick
//   div_value   out  divide value for the prescaler, 0 gates ticks off
//   cnt         out  tick count within the current period
//   period_end  out  one-cycle pulse after each period boundary
//   busy        out  controller not idle
//   cfg_err     out  one-cycle pulse when start is rejected for zero config
// Modports: master = stimulus/host side, slave = controller side.
// -----------------------------------------------------------------------------
interface pwm_timebase_if #(
  parameter int CNT_W = 16
) ();
  logic             cfg_wr;
  logic [15:0]      cfg_div;
  logic [CNT_W-1:0] cfg_period;
  logic             start;
  logic             stop;
  logic             oneshot;
  logic             tick;
  logic [15:0]      div_value;
  logic [CNT_W-1:0] cnt;
  logic             period_end;
  logic             busy;
  logic             cfg_err;

  modport master (
    output cfg_wr, cfg_div, cfg_period, start, stop, oneshot, tick,
    input  div_value, cnt, period_end, busy, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_div, cfg_period, start, stop, oneshot, tick,
    output div_value, cnt, period_end, busy, cfg_err
  );
endinterface

// File: rtl/pwm_timebase_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_timebase_ctrl
// Purpose : PWM period timebase controller. It counts prescaler ticks within a
//           period, pulses period_end at each period boundary, and applies
//           configuration updates only at safe points: right away in IDLE, or
//           at a period boundary while running. Stop is graceful and takes
//           effect at the next boundary.
//
// Optional feature: macro PWM_TIMEBASE_ONESHOT_EN. When it is defined, the
//           oneshot input ends RUN after one period. When it is undefined,
//           oneshot is ignored and RUN continues until a stop request.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   rst_n        in   asynchronous active-low reset
//   bus          --   pwm_timebase_if.slave (config, control, status)
//   o_dbg_state  out  current FSM state (0 IDLE, 1 RUN, 2 STOP_PEND)
// -----------------------------------------------------------------------------
module pwm_timebase_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_timebase_if.slave         bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [15:0]      r_pend_div;
  logic [CNT_W-1:0] r_pend_period;
  logic             r_upd_pend;
  logic [15:0]      r_act_div;
  logic [CNT_W-1:0] r_act_period;
  logic [15:0]      r_div_value;
  logic [CNT_W-1:0] r_cnt;
  logic             r_period_end;
  logic             r_cfg_err;

  logic             w_active;
  logic             w_boundary;
  logic             w_load_act;
  logic [15:0]      w_act_div_nxt;
  logic [CNT_W-1:0] w_act_period_nxt;
  logic             w_start;
  logic             w_cfg_zero;
  logic             w_oneshot;
  logic             w_cfg_err_nxt;

`ifdef PWM_TIMEBASE_ONESHOT_EN
  assign w_oneshot = bus.oneshot;
`else
  logic w_unused_oneshot;
  assign w_unused_oneshot = bus.oneshot;
  assign w_oneshot        = 1'b0;
`endif

  assign w_active   = (r_state != ST_IDLE);
  assign w_boundary = w_active & bus.tick & (r_cnt == r_act_period);

  // Pending config reaches the active registers on any cycle in IDLE, and
  // only at a boundary while running. The non-blocking update means a cfg_wr
  // on the same cycle as a boundary writes pending, while the boundary still
  // moves the older pending value.
  assign w_load_act       = r_upd_pend & (w_active ? w_boundary : 1'b1);
  assign w_act_div_nxt    = w_load_act ? r_pend_div    : r_act_div;
  assign w_act_period_nxt = w_load_act ? r_pend_period : r_act_period;

  // Stop wins over a simultaneous start.
  assign w_start = bus.start & ~bus.stop;

  // Start is validated against the config that will be active once this edge
  // has passed. RUN can then never begin with a zero divide or period that was
  // loaded in the same cycle.
  assign w_cfg_zero = (w_act_div_nxt == 16'd0) || (w_act_period_nxt == '0);

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cfg_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_cfg_zero) w_cfg_err_nxt = 1'b1;
          else            w_state_nxt   = ST_RUN;
        end
      end
      ST_RUN: begin
        // A boundary and a stop on the same cycle: the boundary completes, and
        // the stop then waits for the next boundary.
        if (w_boundary && w_oneshot) w_state_nxt = ST_IDLE;
        else if (bus.stop)           w_state_nxt = ST_STOP_PEND;
      end
      ST_STOP_PEND: begin
        // A start cancels the pending stop, even on the boundary cycle itself.
        if (w_start)         w_state_nxt = ST_RUN;
        else if (w_boundary) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Config registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_div    <= 16'd0;
      r_pend_period <= '0;
      r_upd_pend    <= 1'b0;
      r_act_div     <= 16'd0;
      r_act_period  <= '0;
    end else begin
      if (bus.cfg_wr) begin
        r_pend_div    <= bus.cfg_div;
        r_pend_period <= bus.cfg_period;
      end
      // A fresh write keeps the flag set even when a load happens this cycle.
      if (bus.cfg_wr)      r_upd_pend <= 1'b1;
      else if (w_load_act) r_upd_pend <= 1'b0;
      r_act_div    <= w_act_div_nxt;
      r_act_period <= w_act_period_nxt;
    end
  end

  // Counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_div_value  <= 16'd0;
      r_period_end <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      // The counter wraps at the boundary, before any new period takes
      // effect, so it never exceeds the active period.
      if (!w_active || w_boundary) r_cnt <= '0;
      else if (bus.tick)           r_cnt <= r_cnt + CNT_W'(1);
      // div_value follows the state being entered, so the prescaler is gated
      // off on the same edge on which the FSM returns to IDLE.
      r_div_value  <= (w_state_nxt != ST_IDLE) ? w_act_div_nxt : 16'd0;
      r_period_end <= w_boundary;
      r_cfg_err    <= w_cfg_err_nxt;
    end
  end

  assign bus.div_value  = r_div_value;
  assign bus.cnt        = r_cnt;
  assign bus.period_end = r_period_end;
  assign bus.cfg_err    = r_cfg_err;
  assign bus.busy       = w_active;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_timebase_ctrl
// Directed bench for pwm_timebase_ctrl. The stimulus pushes the expected
// event records (period_end / cfg_err) into exp_q. A monitor pops one record
// and compares it whenever the DUT raises an event pulse. Each record packs
// {cfg_err, period_end, busy, div_value, ticks since the previous event}.
// Level checks (cnt, busy, state) are made inline, 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_pwm_timebase_ctrl;
  localparam int W = 35;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int n_ticks = 0;
  logic [W-1:0] exp_q[$];

  pwm_timebase_if #(.CNT_W(16)) bus ();

  pwm_timebase_ctrl #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(input logic err, input logic pe, input logic bsy,
                                      input logic [15:0] div, input logic [15:0] tk);
    return {err, pe, bsy, div, tk};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (!rst_n) begin
      n_ticks = 0;
    end else begin
      if (bus.period_end || bus.cfg_err) begin
        got = ev(bus.cfg_err, bus.period_end, bus.busy, bus.div_value, n_ticks[15:0]);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event t=%0t got=%h required=none", $time, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL event t=%0t got=%h required=%h", $time, got, exp);
          end
        end
        n_ticks = 0;
      end
      if (bus.tick) n_ticks++;
    end
  end

  // Driver tasks
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input int div);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    cyc(div);
  endtask

  task automatic cfg(input logic [15:0] div, input logic [15:0] period);
    bus.cfg_wr     = 1'b1;
    bus.cfg_div    = div;
    bus.cfg_period = period;
    cyc();
    bus.cfg_wr = 1'b0;
    cyc();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.cfg_wr     = 1'b0;
    bus.cfg_div    = 16'd0;
    bus.cfg_period = 16'd0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.oneshot    = 1'b0;
    bus.tick       = 1'b0;
    #3;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_cnt", 32'(bus.cnt), 0);
    check("rst_div", 32'(bus.div_value), 0);
    check("rst_pe", 32'(bus.period_end), 0);
    check("rst_state", 32'(dbg_state), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc();

    // Basic run with div=1 and period=3, followed by a graceful stop at cnt=1
    cfg(16'd1, 16'd3);
    pulse_start();
    check("run_busy", 32'(bus.busy), 1);
    check("run_div", 32'(bus.div_value), 1);
    check("run_cnt0", 32'(bus.cnt), 0);
    check("run_state", 32'(dbg_state), 1);
    exp_q.push_back(ev(0, 1, 1, 16'd1, 16'd4));
    exp_q.push_back(ev(0, 1, 1, 16'd1, 16'd4));
    for (int i = 0; i < 8; i++) begin
      do_tick(1);
      check("run_cnt_seq", 32'(bus.cnt), (i + 1) % 4);
    end
    exp_q.push_back(ev(0, 1, 0, 16'd0, 16'd4));
    do_tick(1);
    pulse_stop();
    check("stop_state", 32'(dbg_state), 2);
    check("stop_busy", 32'(bus.busy), 1);
    check("stop_div", 32'(bus.div_value), 1);
    repeat (3) do_tick(1);
    check("stopped_busy", 32'(bus.busy), 0);
    check("stopped_div", 32'(bus.div_value), 0);
    check("stopped_state", 32'(dbg_state), 0);

    // Zero divide or zero period rejects the start
    cfg(16'd0, 16'd5);
    exp_q.push_back(ev(1, 0, 0, 16'd0, 16'd0));
    pulse_start();
    check("zdiv_err", 32'(bus.cfg_err), 1);
    check("zdiv_busy", 32'(bus.busy), 0);
    check("zdiv_div", 32'(bus.div_value), 0);
    cyc();
    check("zdiv_err_1cyc", 32'(bus.cfg_err), 0);
    cfg(16'd1, 16'd0);
    exp_q.push_back(ev(1, 0, 0, 16'd0, 16'd0));
    pulse_start();
    check("zper_busy", 32'(bus.busy), 0);

    // Reconfiguring mid-period, and a cfg_wr that lands on a boundary
    cfg(16'd1, 16'd3);
    pulse_start();
    exp_q.push_back(ev(0, 1, 1, 16'd1, 16'd4));
    exp_q.push_back(ev(0, 1, 1, 16'd1, 16'd2));
    exp_q.push_back(ev(0, 1, 1, 16'd1, 16'd2));
    exp_q.push_back(ev(0, 1, 1, 16'd1, 16'd2));
    exp_q.push_back(ev(0, 1, 0, 16'd0, 16'd4));
    do_tick(1);
    bus.cfg_wr     = 1'b1;
    bus.cfg_div    = 16'd1;
    bus.cfg_period = 16'd1;
    cyc();
    bus.cfg_wr = 1'b0;
    repeat (3) do_tick(1);
    check("upd_cur_end", 32'(bus.cnt), 0);
    do_tick(1);
    check("upd_new_cnt1", 32'(bus.cnt), 1);
    do_tick(1);
    check("upd_new_wrap", 32'(bus.cnt), 0);
    do_tick(1);
    bus.tick       = 1'b1;
    bus.cfg_wr     = 1'b1;
    bus.cfg_period = 16'd3;
    cyc();
    bus.tick   = 1'b0;
    bus.cfg_wr = 1'b0;
    cyc();
    check("bnd_wr_wrap", 32'(bus.cnt), 0);
    do_tick(1);
    do_tick(1);
    check("bnd_wr_old_period", 32'(bus.cnt), 0);
    pulse_stop();
    repeat (3) do_tick(1);
    check("bnd_wr_new_cnt3", 32'(bus.cnt), 3);
    do_tick(1);
    check("upd_idle", 32'(bus.busy), 0);

    // Oneshot level
    bus.oneshot = 1'b1;
    cfg(16'd1, 16'd2);
    pulse_start();
`ifdef PWM_TIMEBASE_ONESHOT_EN
    exp_q.push_back(ev(0, 1, 0, 16'd0, 16'd3));
    repeat (3) do_tick(1);
    check("oneshot_busy", 32'(bus.busy), 0);
    check("oneshot_cnt", 32'(bus.cnt), 0);
    bus.oneshot = 1'b0;
`else
    exp_q.push_back(ev(0, 1, 1, 16'd1, 16'd3));
    exp_q.push_back(ev(0, 1, 0, 16'd0, 16'd3));
    repeat (3) do_tick(1);
    check("oneshot_ignored_busy", 32'(bus.busy), 1);
    pulse_stop();
    bus.oneshot = 1'b0;
    repeat (3) do_tick(1);
    check("oneshot_off_idle", 32'(bus.busy), 0);
`endif

    // Start and stop interplay
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_idle_state", 32'(dbg_state), 0);
    pulse_start();
    check("ss_run", 32'(dbg_state), 1);
    do_tick(1);
    pulse_stop();
    check("ss_stop_pend", 32'(dbg_state), 2);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_sp_stopwins", 32'(dbg_state), 2);
    pulse_start();
    check("ss_cancel_state", 32'(dbg_state), 1);
    check("ss_cancel_cnt", 32'(bus.cnt), 1);
    do_tick(1);
    check("ss_cnt2", 32'(bus.cnt), 2);

    // Reset in the middle of a period
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(bus.busy), 0);
    check("mrst_cnt", 32'(bus.cnt), 0);
    check("mrst_div", 32'(bus.div_value), 0);
    check("mrst_pe", 32'(bus.period_end), 0);
    check("mrst_err", 32'(bus.cfg_err), 0);
    check("mrst_state", 32'(dbg_state), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    repeat (3) do_tick(1);
    check("post_rst_cnt", 32'(bus.cnt), 0);
    check("post_rst_busy", 32'(bus.busy), 0);
    // The active config was cleared, so the start is rejected. The three idle
    // ticks above are counted in the record.
    exp_q.push_back(ev(1, 0, 0, 16'd0, 16'd3));
    pulse_start();
    check("post_rst_start_busy", 32'(bus.busy), 0);

    cyc(4);
    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_timebase_ctrl.md
PWM_TIMEBASE_CTRL -- requirements
Module: pwm_timebase_ctrl

Interface
REQ-001: CNT_W, 16, width of period counter and period config.
REQ-002: clk  input  1  system clock; all logic on rising edge.
REQ-003: rst_n  input  1  asynchronous active-low reset.
REQ-004: cfg_wr  input  1  one-cycle strobe; captures cfg_div and cfg_period into pending registers.
REQ-005: cfg_div  input  16  prescaler divide value (tick every cfg_div+1 cycles).
REQ-006: cfg_period  input  CNT_W  period length minus one, counted in ticks.
REQ-007: start  input  1  one-cycle start request.
REQ-008: stop  input  1  one-cycle stop request; graceful, takes effect at period boundary.
REQ-009: oneshot  input  1  level; when high, RUN ends after one period.
REQ-010: tick  input  1  prescaler tick.
REQ-011: div_value  output  16  divide value driven to prescaler; 0 gates ticks off.
REQ-012: cnt  output  CNT_W  current tick count within period.
REQ-013: period_end  output  1  one-cycle pulse at period boundary.
REQ-014: busy  output  1  high when state is not IDLE.
REQ-015: cfg_err  output  1  one-cycle pulse on start rejected for zero config.

Function
REQ-016: FSM states SHALL be IDLE, RUN, STOP_PEND.
REQ-017: Pending regs and upd_pend flag set on cfg_wr; active regs (act_div, act_period) loaded from pending in IDLE on the cycle after cfg_wr, in RUN/STOP_PEND only at a period boundary.
REQ-018: cfg_wr in the same cycle as a boundary SHALL write pending; the boundary transfers the pre-write pending value; the new value applies at the next boundary.
REQ-019: div_value SHALL be 0 in IDLE and act_div in RUN/STOP_PEND, registered.
REQ-020: IDLE + start: if act_div != 0 and act_period != 0 -> RUN, cnt=0; else stay IDLE, pulse cfg_err next cycle.
REQ-021: RUN/STOP_PEND, tick high and cnt != act_period: cnt increments by 1.
REQ-022: RUN/STOP_PEND, tick high and cnt == act_period (boundary): cnt <= 0, period_end high next cycle for exactly one cycle; period = (act_period+1) ticks.
REQ-023: At boundary: STOP_PEND -> IDLE; RUN with oneshot high -> IDLE; otherwise remain in state.
REQ-024: RUN + stop -> STOP_PEND; stop in IDLE ignored; stop in STOP_PEND no effect.
REQ-025: STOP_PEND + start -> RUN (stop cancelled), cnt unaffected.
REQ-026: start and stop same cycle: stop wins (IDLE stays IDLE, RUN -> STOP_PEND).
REQ-027: Boundary and stop in same cycle in RUN: boundary processed, state -> STOP_PEND, stop applies at next boundary.
REQ-028: cnt SHALL never exceed act_period; if act_period lowered below cnt at boundary, cnt already 0.
REQ-029: busy combinational from state.

Reset
REQ-030: rst_n low SHALL immediately force state=IDLE, div_value=0, cnt=0, period_end=0, cfg_err=0, pending/active regs=0, upd_pend=0; reset mid-period discards all progress.

Configuration
REQ-031: Macro PWM_TIMEBASE_ONESHOT_EN defined: oneshot input honoured per REQ-023.
REQ-032: Macro undefined: oneshot ignored; RUN continues until stop.

Verification
REQ-033: cfg_wr div=1 period=3, start -> tick every 2 cycles, period_end every 8 cycles, cnt 0,1,2,3,0.
REQ-034: start with div=0 period=5 -> cfg_err one pulse, busy stays 0, div_value stays 0.
REQ-035: RUN period=3, stop at cnt=1 -> STOP_PEND, one further period_end, then IDLE, div_value=0.
REQ-036: RUN period=3, cfg_wr period=1 at cnt=1 -> current period 4 ticks, following periods 2 ticks.
REQ-037: ONESHOT_EN build, oneshot=1, period=2 -> exactly one period_end, then busy=0; non-EN build -> periodic.
REQ-038: rst_n low at cnt=2 in RUN -> all outputs zero same cycle; after release no ticks until new start.
